mdu_issue: RTL and testbench

MDU_ISSUE -- requirements
Module: mdu_issue

---
 rtl/mdu_issue.sv | 141 ++++++++++++++
 tb/tb_mdu_issue.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_issue.sv
// Issue sequencer between the E-stage and the multiply/divide unit: accepts one
// MDU instruction at a time, drives it to the unit for one cycle, waits out
// multiply/divide latency and returns MFHI/MFLO read data as a registered pulse.
module mdu_issue (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  output logic        req_ready,
  output logic        stall,
  output logic [3:0]  mdu_op,
  output logic [31:0] mdu_a,
  output logic [31:0] mdu_b,
  input  logic        md_busy,
  input  logic [31:0] md_out,
  output logic [31:0] rd_data,
  output logic        rd_valid
);

  localparam int unsigned OP_W   = 4;
  localparam int unsigned DATA_W = 32;

  // Shared MDU opcode encodings
  localparam logic [OP_W-1:0] MDU_NONE  = OP_W'(0);
  localparam logic [OP_W-1:0] MDU_MULT  = OP_W'(1);
  localparam logic [OP_W-1:0] MDU_MULTU = OP_W'(2);
  localparam logic [OP_W-1:0] MDU_DIV   = OP_W'(3);
  localparam logic [OP_W-1:0] MDU_DIVU  = OP_W'(4);
  localparam logic [OP_W-1:0] MDU_MFHI  = OP_W'(5);
  localparam logic [OP_W-1:0] MDU_MFLO  = OP_W'(6);
  localparam logic [OP_W-1:0] MDU_MTHI  = OP_W'(7);
  localparam logic [OP_W-1:0] MDU_MTLO  = OP_W'(8);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [OP_W-1:0]     op_q, op_d;
  logic [OP_W-1:0]     mdu_op_d;
  logic [DATA_W-1:0]   mdu_a_d, mdu_b_d;
  logic [DATA_W-1:0]   rd_data_d;
  logic                rd_valid_d;
  logic                accept;

  // Opcodes that actually reach the unit; everything else is accepted and dropped
  function automatic logic is_issuable(input logic [OP_W-1:0] op);
    return (op >= MDU_MULT) && (op <= MDU_MTLO);
  endfunction

  // Multi-cycle operations that keep the unit busy after issue
  function automatic logic is_long(input logic [OP_W-1:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // HI/LO reads that return data through rd_data
  function automatic logic is_read(input logic [OP_W-1:0] op);
    return (op == MDU_MFHI) || (op == MDU_MFLO);
  endfunction

  // Handshake: ready only when idle, out of reset and the unit is not busy
  assign req_ready = reset && (state_q == IDLE) && !md_busy;
  assign stall     = req_valid && !req_ready;
  assign accept    = req_valid && req_ready;

  // State register
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    mdu_op_d   = MDU_NONE;
    mdu_a_d    = mdu_a;
    mdu_b_d    = mdu_b;
    rd_data_d  = rd_data;
    rd_valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d = req_op;
          if (is_issuable(req_op)) begin
            state_d  = ISSUE;
            mdu_op_d = req_op;
            mdu_a_d  = req_a;
            mdu_b_d  = req_b;
          end
        end
      end
      ISSUE: begin
        if (is_long(op_q)) begin
          state_d = WAIT;
        end else begin
          state_d = IDLE;
          if (is_read(op_q)) begin
            rd_data_d  = md_out;
            rd_valid_d = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!md_busy) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Registered unit drive, latched opcode and read-data outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q     <= MDU_NONE;
      mdu_op   <= MDU_NONE;
      mdu_a    <= '0;
      mdu_b    <= '0;
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      op_q     <= op_d;
      mdu_op   <= mdu_op_d;
      mdu_a    <= mdu_a_d;
      mdu_b    <= mdu_b_d;
      rd_data  <= rd_data_d;
      rd_valid <= rd_valid_d;
    end
  end

endmodule

// File: tb/tb_mdu_issue.sv
// Directed bench for mdu_issue with a small behavioural multiply/divide unit.
module tb_mdu_issue;

  localparam logic [3:0] MDU_NONE  = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [3:0]  req_op;
  logic [31:0] req_a, req_b;
  logic        req_ready, stall;
  logic [3:0]  mdu_op;
  logic [31:0] mdu_a, mdu_b;
  logic        md_busy;
  logic [31:0] md_out;
  logic [31:0] rd_data;
  logic        rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  // Model unit state
  logic [31:0] hi = '0, lo = '0;
  int          busy_cnt = 0;
  logic        force_busy = 1'b0;
  logic [63:0] prod;

  // Monitor state
  int          issue_cnt = 0;
  logic [3:0]  iss_op;
  logic [31:0] iss_a, iss_b;
  logic [31:0] rd_log[$];

  always #5 clk = ~clk;

  mdu_issue dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_ready(req_ready),
    .stall    (stall),
    .mdu_op   (mdu_op),
    .mdu_a    (mdu_a),
    .mdu_b    (mdu_b),
    .md_busy  (md_busy),
    .md_out   (md_out),
    .rd_data  (rd_data),
    .rd_valid (rd_valid)
  );

  assign md_busy = force_busy || (busy_cnt != 0);
  assign md_out  = (mdu_op == MDU_MFHI) ? hi : lo;

  // Behavioural unit: multiply busy 5 cycles, divide busy 10 cycles
  always @(posedge clk) begin
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    case (mdu_op)
      MDU_MULT: begin
        prod = {{32{mdu_a[31]}}, mdu_a} * {{32{mdu_b[31]}}, mdu_b};
        hi <= prod[63:32]; lo <= prod[31:0]; busy_cnt <= 5;
      end
      MDU_MULTU: begin
        prod = {32'b0, mdu_a} * {32'b0, mdu_b};
        hi <= prod[63:32]; lo <= prod[31:0]; busy_cnt <= 5;
      end
      MDU_DIV: begin
        if (mdu_b != 0) begin
          lo <= $signed(mdu_a) / $signed(mdu_b);
          hi <= $signed(mdu_a) % $signed(mdu_b);
        end
        busy_cnt <= 10;
      end
      MDU_DIVU: begin
        if (mdu_b != 0) begin
          lo <= mdu_a / mdu_b;
          hi <= mdu_a % mdu_b;
        end
        busy_cnt <= 10;
      end
      MDU_MTHI: hi <= mdu_a;
      MDU_MTLO: lo <= mdu_a;
      default: ;
    endcase
  end

  // Record every issue cycle and every read pulse
  always @(negedge clk) begin
    if (mdu_op != MDU_NONE) begin
      issue_cnt = issue_cnt + 1;
      iss_op = mdu_op; iss_a = mdu_a; iss_b = mdu_b;
    end
    if (rd_valid === 1'b1) rd_log.push_back(rd_data);
  end

  // Present a request from the next falling edge and hold it until accepted
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      output int waited);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b;
    waited = 0;
    #1;
    while (stall && waited < 100) begin
      @(negedge clk); #1;
      waited++;
    end
    @(posedge clk);
  endtask

  task automatic idle();
    @(negedge clk);
    req_valid = 1'b0; req_op = MDU_NONE; req_a = '0; req_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0; req_valid = 1'b1; req_op = MDU_MULT; req_a = 32'hDEAD_BEEF; req_b = 32'h1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", req_ready); end
    n_cmp++; if (stall !== 1'b1) begin n_err++; $display("FAIL reset_stall: got %b want 1", stall); end
    n_cmp++; if (mdu_op !== MDU_NONE) begin n_err++; $display("FAIL reset_mdu_op: got %h want 0", mdu_op); end
    n_cmp++; if (mdu_a !== 32'h0 || mdu_b !== 32'h0) begin n_err++; $display("FAIL reset_operands: got %h/%h want 0/0", mdu_a, mdu_b); end
    n_cmp++; if (rd_data !== 32'h0 || rd_valid !== 1'b0) begin n_err++; $display("FAIL reset_rd: got %h/%b want 0/0", rd_data, rd_valid); end
    reset = 1'b1; req_valid = 1'b0; req_op = MDU_NONE;
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_err++; $display("FAIL reset_release_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_mult();
    int w, s_iss, s_rd;
    s_iss = issue_cnt; s_rd = rd_log.size();
    send(MDU_MULT, 32'hFFFF_FFFE, 32'd3, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL mult_accept_wait: got %0d want 0", w); end
    send(MDU_MFLO, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 7) begin n_err++; $display("FAIL mult_stall: got %0d want 7", w); end
    n_cmp++; if (issue_cnt - s_iss !== 1) begin n_err++; $display("FAIL mult_issue_cycles: got %0d want 1", issue_cnt - s_iss); end
    n_cmp++; if (iss_op !== MDU_MULT || iss_a !== 32'hFFFF_FFFE || iss_b !== 32'd3) begin
      n_err++; $display("FAIL mult_issue_drive: got %h %h %h want 1 fffffffe 00000003", iss_op, iss_a, iss_b); end
    n_cmp++; if (mdu_a !== 32'hFFFF_FFFE || mdu_op !== MDU_NONE) begin
      n_err++; $display("FAIL mult_hold: got op %h a %h want op 0 a fffffffe", mdu_op, mdu_a); end
    send(MDU_MFHI, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL mflo_stall: got %0d want 1", w); end
    idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_log.size() - s_rd !== 2) begin n_err++; $display("FAIL mult_rd_pulses: got %0d want 2", rd_log.size() - s_rd); end
    n_cmp++; if (rd_log[s_rd] !== 32'hFFFF_FFFA) begin n_err++; $display("FAIL mult_mflo: got %h want fffffffa", rd_log[s_rd]); end
    n_cmp++; if (rd_log[s_rd+1] !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL mult_mfhi: got %h want ffffffff", rd_log[s_rd+1]); end
  endtask

  task automatic test_divu_then_mfhi();
    int w, s_rd;
    s_rd = rd_log.size();
    send(MDU_DIVU, 32'd100, 32'd7, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL divu_accept_wait: got %0d want 0", w); end
    send(MDU_MFHI, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 12) begin n_err++; $display("FAIL divu_stall: got %0d want 12", w); end
    idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_log.size() - s_rd !== 1) begin n_err++; $display("FAIL divu_rd_pulses: got %0d want 1", rd_log.size() - s_rd); end
    n_cmp++; if (rd_log[s_rd] !== 32'd2) begin n_err++; $display("FAIL divu_mfhi: got %h want 00000002", rd_log[s_rd]); end
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (rd_valid !== 1'b0 || rd_data !== 32'd2) begin
      n_err++; $display("FAIL rd_hold: got %b/%h want 0/00000002", rd_valid, rd_data); end
  endtask

  task automatic test_mt_mf_none();
    int w, s_iss, s_rd;
    s_iss = issue_cnt; s_rd = rd_log.size();
    send(MDU_MTLO, 32'h1234_5678, 32'h0, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL mtlo_accept_wait: got %0d want 0", w); end
    send(MDU_MFLO, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL mtlo_stall: got %0d want 1", w); end
    send(MDU_NONE, 32'hAAAA_AAAA, 32'h5555_5555, w);
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL mflo_cost: got %0d want 1", w); end
    send(MDU_NONE, 32'h1, 32'h2, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL none_no_stall: got %0d want 0", w); end
    send(4'hF, 32'h3, 32'h4, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL undef_no_stall: got %0d want 0", w); end
    idle();
    repeat (2) @(negedge clk); #1;
    n_cmp++; if (issue_cnt - s_iss !== 2) begin n_err++; $display("FAIL mt_mf_issues: got %0d want 2", issue_cnt - s_iss); end
    n_cmp++; if (mdu_op !== MDU_NONE || mdu_a !== 32'h0) begin
      n_err++; $display("FAIL none_drive: got op %h a %h want 0/00000000", mdu_op, mdu_a); end
    n_cmp++; if (rd_log.size() - s_rd !== 1) begin n_err++; $display("FAIL mflo_pulses: got %0d want 1", rd_log.size() - s_rd); end
    n_cmp++; if (rd_log[s_rd] !== 32'h1234_5678) begin n_err++; $display("FAIL mflo_data: got %h want 12345678", rd_log[s_rd]); end
  endtask

  task automatic test_back_to_back();
    int w, s_rd;
    s_rd = rd_log.size();
    send(MDU_MTHI, 32'hCAFE_F00D, 32'h0, w);
    n_cmp++; if (w !== 0) begin n_err++; $display("FAIL b2b_mthi_wait: got %0d want 0", w); end
    send(MDU_MFHI, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL b2b_mfhi_wait: got %0d want 1", w); end
    send(MDU_MULTU, 32'hFFFF_FFFF, 32'd2, w);
    n_cmp++; if (w !== 1) begin n_err++; $display("FAIL b2b_multu_wait: got %0d want 1", w); end
    send(MDU_MFHI, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 7) begin n_err++; $display("FAIL b2b_multu_stall: got %0d want 7", w); end
    send(MDU_MFLO, 32'h0, 32'h0, w);
    send(MDU_DIV, 32'hFFFF_FF9C, 32'd7, w);
    send(MDU_MFLO, 32'h0, 32'h0, w);
    n_cmp++; if (w !== 12) begin n_err++; $display("FAIL b2b_div_stall: got %0d want 12", w); end
    send(MDU_MFHI, 32'h0, 32'h0, w);
    idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_log.size() - s_rd !== 5) begin n_err++; $display("FAIL b2b_pulses: got %0d want 5", rd_log.size() - s_rd); end
    n_cmp++; if (rd_log[s_rd] !== 32'hCAFE_F00D) begin n_err++; $display("FAIL b2b_mthi_mfhi: got %h want cafef00d", rd_log[s_rd]); end
    n_cmp++; if (rd_log[s_rd+1] !== 32'h1) begin n_err++; $display("FAIL b2b_multu_hi: got %h want 00000001", rd_log[s_rd+1]); end
    n_cmp++; if (rd_log[s_rd+2] !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b_multu_lo: got %h want fffffffe", rd_log[s_rd+2]); end
    n_cmp++; if (rd_log[s_rd+3] !== 32'hFFFF_FFF2) begin n_err++; $display("FAIL b2b_div_lo: got %h want fffffff2", rd_log[s_rd+3]); end
    n_cmp++; if (rd_log[s_rd+4] !== 32'hFFFF_FFFE) begin n_err++; $display("FAIL b2b_div_hi: got %h want fffffffe", rd_log[s_rd+4]); end
  endtask

  task automatic test_reset_in_wait();
    int w, n;
    send(MDU_DIV, 32'd50, 32'd5, w);
    idle();                       // ISSUE cycle
    @(negedge clk);               // WAIT cycle 1
    @(negedge clk);               // WAIT cycle 2
    @(negedge clk);               // WAIT cycle 3
    reset = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (mdu_op !== MDU_NONE || rd_valid !== 1'b0) begin
      n_err++; $display("FAIL rst_wait_out: got op %h rdv %b want 0/0", mdu_op, rd_valid); end
    n_cmp++; if (mdu_a !== 32'h0) begin n_err++; $display("FAIL rst_wait_operand: got %h want 0", mdu_a); end
    reset = 1'b1;
    @(negedge clk); #1;
    n_cmp++; if (req_ready !== 1'b0 || md_busy !== 1'b1) begin
      n_err++; $display("FAIL rst_wait_busy_ready: got ready %b busy %b want 0/1", req_ready, md_busy); end
    n = 0;
    while (!req_ready && n < 50) begin @(negedge clk); #1; n++; end
    n_cmp++; if (n !== 6) begin n_err++; $display("FAIL rst_wait_ready_delay: got %0d want 6", n); end
    n_cmp++; if (md_busy !== 1'b0) begin n_err++; $display("FAIL rst_wait_busy_clear: got %b want 0", md_busy); end
  endtask

  task automatic test_forced_busy();
    int w, s_rd;
    s_rd = rd_log.size();
    @(negedge clk);
    force_busy = 1'b1; req_valid = 1'b1; req_op = MDU_MTHI; req_a = 32'h55; req_b = 32'h0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (req_ready !== 1'b0 || stall !== 1'b1) begin
        n_err++; $display("FAIL forced_busy_%0d: got ready %b stall %b want 0/1", i, req_ready, stall); end
      @(negedge clk);
    end
    force_busy = 1'b0;
    #1;
    n_cmp++; if (req_ready !== 1'b1 || stall !== 1'b0) begin
      n_err++; $display("FAIL forced_busy_release: got ready %b stall %b want 1/0", req_ready, stall); end
    @(posedge clk);
    send(MDU_MFHI, 32'h0, 32'h0, w);
    idle();
    repeat (2) @(negedge clk);
    n_cmp++; if (rd_log.size() - s_rd !== 1 || rd_log[s_rd] !== 32'h55) begin
      n_err++; $display("FAIL forced_busy_data: got %0d pulses last %h want 1/00000055", rd_log.size() - s_rd, rd_log[s_rd]); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; req_valid = 1'b0; req_op = MDU_NONE; req_a = '0; req_b = '0;
    test_reset();
    test_mult();
    test_divu_then_mfhi();
    test_mt_mf_none();
    test_back_to_back();
    test_reset_in_wait();
    test_forced_busy();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
